// File: rtl/ddc_retune_sequencer.sv
// ddc_retune_sequencer: applies a software-written shadow configuration to
// the DDC datapath on an input-sample boundary. It holds the decimation
// filters in reset while they flush, then blanks the DDC output until a
// programmable number of output samples have refilled the filters. A
// watchdog ends the blanking if output samples stop arriving.
module ddc_retune_sequencer #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned SETTLE_BITS  = 8,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfgWrite,
    input  logic [31:0]            cfgCenterFreq,
    input  logic [7:0]             cfgDecimation,
    input  logic                   cfgBypassCic,
    input  logic                   cfgBypassHb,
    input  logic [SETTLE_BITS-1:0] settleSamples,
    input  logic                   inSync,
    input  logic                   outSync,
    output logic [31:0]            ddcCenterFreq,
    output logic [7:0]             adcDecimation,
    output logic                   bypassCic,
    output logic                   bypassHb,
    output logic                   filterReset,
    output logic                   outValid,
    output logic                   busy,
    output logic                   timeoutErr
);

    localparam int unsigned FLUSH_BITS = $clog2(RESET_CYCLES + 1);
    localparam logic [FLUSH_BITS-1:0]   FLUSH_LOAD = FLUSH_BITS'(RESET_CYCLES);
    localparam logic [FLUSH_BITS-1:0]   FLUSH_LAST = FLUSH_BITS'(1);
    localparam logic [TIMEOUT_BITS-1:0] WD_MAX     = '1;
    localparam logic [TIMEOUT_BITS-1:0] WD_PRE     = WD_MAX - TIMEOUT_BITS'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIGN  = 2'd1,
        FLUSH  = 2'd2,
        SETTLE = 2'd3
    } seqState_t;

    seqState_t               state;
    logic [FLUSH_BITS-1:0]   flushCnt;
    logic [SETTLE_BITS-1:0]  settleCnt;
    logic [SETTLE_BITS-1:0]  settleTarget;
    logic [TIMEOUT_BITS-1:0] watchdog;

    logic [31:0] shadowFreq;
    logic [7:0]  shadowDec;
    logic        shadowBypassCic;
    logic        shadowBypassHb;

    logic [31:0] commitFreq;
    logic [7:0]  commitDec;
    logic        commitBypassCic;
    logic        commitBypassHb;

    // Shadow set captures the requested configuration on every write.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadowFreq      <= '0;
            shadowDec       <= '0;
            shadowBypassCic <= 1'b0;
            shadowBypassHb  <= 1'b0;
        end else if (cfgWrite) begin
            shadowFreq      <= cfgCenterFreq;
            shadowDec       <= cfgDecimation;
            shadowBypassCic <= cfgBypassCic;
            shadowBypassHb  <= cfgBypassHb;
        end
    end

    // A write landing on the commit cycle must win over the older shadow.
    always_comb begin
        commitFreq      = shadowFreq;
        commitDec       = shadowDec;
        commitBypassCic = shadowBypassCic;
        commitBypassHb  = shadowBypassHb;
        if (cfgWrite) begin
            commitFreq      = cfgCenterFreq;
            commitDec       = cfgDecimation;
            commitBypassCic = cfgBypassCic;
            commitBypassHb  = cfgBypassHb;
        end
    end

    // Retune sequencer; outputs are set on the transition into each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FLUSH;
            flushCnt      <= FLUSH_LOAD;
            settleCnt     <= '0;
            settleTarget  <= '0;
            watchdog      <= '0;
            ddcCenterFreq <= '0;
            adcDecimation <= '0;
            bypassCic     <= 1'b0;
            bypassHb      <= 1'b0;
            filterReset   <= 1'b1;
            outValid      <= 1'b0;
            busy          <= 1'b1;
            timeoutErr    <= 1'b0;
        end else begin
            if (cfgWrite) begin
                timeoutErr <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cfgWrite) begin
                        state    <= ALIGN;
                        outValid <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ALIGN: begin
                    if (inSync) begin
                        state         <= FLUSH;
                        flushCnt      <= FLUSH_LOAD;
                        filterReset   <= 1'b1;
                        ddcCenterFreq <= commitFreq;
                        adcDecimation <= commitDec;
                        bypassCic     <= commitBypassCic;
                        bypassHb      <= commitBypassHb;
                    end
                end
                FLUSH: begin
                    if (cfgWrite) begin
                        state       <= ALIGN;
                        filterReset <= 1'b0;
                    end else if (flushCnt == FLUSH_LAST) begin
                        state        <= SETTLE;
                        filterReset  <= 1'b0;
                        settleTarget <= settleSamples;
                        settleCnt    <= '0;
                        watchdog     <= '0;
                    end else begin
                        flushCnt <= flushCnt - FLUSH_BITS'(1);
                    end
                end
                SETTLE: begin
                    if (cfgWrite) begin
                        state <= ALIGN;
                    end else if ((settleTarget == '0) ||
                                 (outSync && (settleCnt == settleTarget - SETTLE_BITS'(1)))) begin
                        state    <= IDLE;
                        outValid <= 1'b1;
                        busy     <= 1'b0;
                    end else if (outSync) begin
                        settleCnt <= settleCnt + SETTLE_BITS'(1);
                        watchdog  <= '0;
                    end else if (watchdog >= WD_PRE) begin
                        // Watchdog saturates: give up on refill and reopen the output.
                        watchdog   <= WD_MAX;
                        timeoutErr <= 1'b1;
                        state      <= IDLE;
                        outValid   <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        watchdog <= watchdog + TIMEOUT_BITS'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ddc_retune_sequencer.md
# ddc_retune_sequencer

Controller that sequences configuration changes into the DDC datapath: center frequency, ADC decimation and the CIC/halfband bypass selects. Software writes a shadow set. The block applies it on an input-sample boundary, holds the decimation filters in reset so they flush, then blanks the DDC output for a programmable number of output samples while the filters refill. It sits between the DDC register file and the DDC datapath. It drives the datapath's active configuration, its filter reset and an output-valid qualifier consumed by downstream demod blocks.

## Interface
Parameters:
- RESET_CYCLES, 16, clocks filterReset is held high per retune (≥2).
- SETTLE_BITS, 8, width of settle-sample count.
- TIMEOUT_BITS, 20, width of the no-output-sample watchdog counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cfgWrite  in  1  one-cycle strobe: capture shadow inputs and request retune
- cfgCenterFreq  in  32  requested DDC center frequency word
- cfgDecimation  in  8  requested ADC decimation count
- cfgBypassCic  in  1  requested CIC bypass
- cfgBypassHb  in  1  requested 2nd-halfband bypass
- settleSamples  in  SETTLE_BITS  output samples to blank after flush (0 = none)
- inSync  in  1  input-rate sample strobe (first-halfband syncOut)
- outSync  in  1  DDC output sample strobe
- ddcCenterFreq  out  32  active center frequency
- adcDecimation  out  8  active decimation
- bypassCic  out  1  active CIC bypass
- bypassHb  out  1  active halfband bypass
- filterReset  out  1  reset to CIC, 2nd halfband, comp filters
- outValid  out  1  qualifies DDC output samples
- busy  out  1  retune in progress
- timeoutErr  out  1  sticky: settle watchdog expired; cleared by next cfgWrite or reset

## Operation
- States: IDLE, ALIGN, FLUSH, SETTLE.
- Shadow registers load on every cfgWrite, in any state.
- IDLE: outValid=1, busy=0. cfgWrite -> ALIGN.
- ALIGN: outValid=0, busy=1. Wait for inSync. On the inSync cycle, copy shadow to the active outputs, load the flush counter with RESET_CYCLES and go to FLUSH.
- FLUSH: filterReset=1. Decrement the counter each clock. At 0, go to SETTLE, load the settle counter from settleSamples and clear the watchdog.
- SETTLE: count outSync pulses. When the count reaches settleSamples (immediately if 0), go to IDLE.
  - The watchdog increments each clock and clears on every outSync.
  - If the watchdog saturates at all-ones: set timeoutErr and go to IDLE.
- A cfgWrite in ALIGN, FLUSH or SETTLE restarts the sequence at ALIGN with the new shadow values. The active outputs are not touched until the next ALIGN commit. A partially counted flush or settle is discarded.
- cfgWrite and inSync in the same cycle while in ALIGN: the new shadow (this cycle's cfg inputs) is the value committed.
- After reset: active config = 0, and the state is FLUSH with the counter loaded, so a power-up flush runs with default config before outValid first rises.
- Counters do not wrap. The watchdog saturates. A settleSamples change mid-SETTLE is ignored; it was latched on entry.

## Timing
- All outputs registered.
- Reset values: ddcCenterFreq=0, adcDecimation=0, bypassCic=0, bypassHb=0, filterReset=1, outValid=0, busy=1, timeoutErr=0.
- cfgWrite in cycle N (from IDLE): busy=1 and outValid=0 in N+1.
- inSync seen in cycle M (in ALIGN): active config and filterReset=1 appear in M+1. filterReset stays high exactly RESET_CYCLES clocks (M+1 … M+RESET_CYCLES).
- SETTLE: the outSync that completes the count is cycle K. outValid=1 and busy=0 in K+1. That sample itself is not qualified.
- settleSamples=0: outValid rises one clock after filterReset falls.

## Test plan
- Power-up: release reset, no cfgWrite, settleSamples=4, outSync every 10 clocks.
  - filterReset high 16 clocks from reset.
  - outValid rises 1 clock after the 4th post-flush outSync.
  - All config outputs stay 0.
- Retune: cfgWrite centerFreq=0x12345678, decimation=3, inSync every 4 clocks.
  - Outputs update exactly 1 clock after the first inSync following the write.
  - filterReset pulses for 16 clocks after that.
  - outValid is low throughout.
- Restart: second cfgWrite (decimation=7) issued mid-FLUSH.
  - Sequence returns to ALIGN.
  - adcDecimation goes to 7 only at the next inSync.
  - Another full 16-cycle filterReset follows.
- Simultaneous: cfgWrite(freq=0xA) and inSync in the same ALIGN cycle → freq 0xA committed next clock.
- Watchdog: TIMEOUT_BITS=6, no outSync in SETTLE.
  - After 63 clocks, timeoutErr=1 and outValid=1.
  - The next cfgWrite clears timeoutErr.
- Reset mid-SETTLE: all outputs return to reset values next clock and the power-up flush reruns.
